gpio_ctrl: RTL and testbench

Memory-mapped GPIO peripheral that sits on the processor's internal bus and directly drives the board-level GPIOOut pins (LED bank). It also samples external input pins through a 2-flop synchronizer and latches rising edges into a sticky status register. A maskable level interrupt request is raised toward the core. It is a slave-only bus stage with single-cycle registered response.

---
 rtl/gpio_ctrl_pkg.sv | 30 +++
 rtl/gpio_in_sync.sv | 33 +++
 rtl/gpio_ctrl.sv | 117 +++++++++++
 tb/tb_gpio_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_pkg.sv
// Shared constants and types for the GPIO peripheral.
// No logic; used by gpio_ctrl and gpio_in_sync.
// No backpressure: constants only.
package gpio_ctrl_pkg;

    localparam int GPIO_DATA_W = 32;

    localparam logic [1:0] GPIO_ADDR_IN   = 2'd0;
    localparam logic [1:0] GPIO_ADDR_OUT  = 2'd1;
    localparam logic [1:0] GPIO_ADDR_EDGE = 2'd2;
    localparam logic [1:0] GPIO_ADDR_MASK = 2'd3;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic {
        ACK_IDLE = 1'b0,
        ACK_BUSY = 1'b1
    } ack_state_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] idx;
    } bus_req_t;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop input synchronizer with a previous-value register for rising-edge detection.
// Latency: level 2 clocks after the pin, rise pulse visible in the 3rd cycle.
// No backpressure: free-running every clock.
module gpio_in_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic [W-1:0] pin,
    output logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level = sync2;
    assign rise  = sync2 & ~prev;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: output pin register, synchronized inputs, sticky rising-edge status, masked irq.
// Latency: write lands on the access edge; read data and rdy_ registered one cycle after the access.
// No backpressure: every access is acknowledged the next cycle, back-to-back, no wait states.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int                OUT_CH    = 8,
    parameter int                IN_CH     = 8,
    parameter int                DATA_W    = GPIO_DATA_W,
    parameter logic [OUT_CH-1:0] OUT_RESET = '0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              rdy_,
    input  logic [IN_CH-1:0]  gpioIn,
    output logic [OUT_CH-1:0] GPIOOut,
    output logic              irq
);

    bus_req_t          req;
    ack_state_t        ack_q;
    ack_state_t        ack_nxt;
    logic [OUT_CH-1:0] out_q;
    logic [IN_CH-1:0]  mask_q;
    logic [IN_CH-1:0]  edge_q;
    logic [IN_CH-1:0]  edge_clr;
    logic [IN_CH-1:0]  in_level;
    logic [IN_CH-1:0]  in_rise;
    logic [DATA_W-1:0] rd_nxt;
    logic [DATA_W-1:0] rd_q;
    logic              irq_q;
    logic              unused_wr;

    // Only the low channel bits of write data are architected.
    assign unused_wr = ^wrData;

    gpio_in_sync #(
        .W (IN_CH)
    ) u_in_sync (
        .clk    (clk),
        .reset_ (reset_),
        .pin    (gpioIn),
        .level  (in_level),
        .rise   (in_rise)
    );

    always_comb begin
        req     = '0;
        req.idx = addr;
        if (cs_ == ASSERT_L && as_ == ASSERT_L) begin
            req.rd = (rw == RW_READ);
            req.wr = (rw == RW_WRITE);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            out_q  <= OUT_RESET;
            mask_q <= '0;
        end else if (req.wr) begin
            if (req.idx == GPIO_ADDR_OUT) out_q  <= wrData[OUT_CH-1:0];
            if (req.idx == GPIO_ADDR_MASK) mask_q <= wrData[IN_CH-1:0];
        end
    end

    // A fresh edge on a bit overrides a simultaneous write-1-to-clear.
    assign edge_clr = (req.wr && req.idx == GPIO_ADDR_EDGE) ? wrData[IN_CH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= (edge_q & ~edge_clr) | in_rise;
            irq_q  <= |(edge_q & mask_q);
        end
    end

    always_comb begin
        rd_nxt = '0;
        if (req.rd) begin
            case (req.idx)
                GPIO_ADDR_IN:   rd_nxt[IN_CH-1:0]  = in_level;
                GPIO_ADDR_OUT:  rd_nxt[OUT_CH-1:0] = out_q;
                GPIO_ADDR_EDGE: rd_nxt[IN_CH-1:0]  = edge_q;
                GPIO_ADDR_MASK: rd_nxt[IN_CH-1:0]  = mask_q;
            endcase
        end
    end

    always_comb begin
        ack_nxt = ACK_IDLE;
        if (req.rd || req.wr) ack_nxt = ACK_BUSY;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ack_q <= ACK_IDLE;
            rd_q  <= '0;
        end else begin
            ack_q <= ack_nxt;
            rd_q  <= rd_nxt;
        end
    end

    assign rdy_    = (ack_q == ACK_BUSY) ? ASSERT_L : DEASSERT_L;
    assign rdData  = rd_q;
    assign GPIOOut = out_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register-level model compared every cycle plus directed literal checks.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        cs_ = 1'b1;
    logic        as_ = 1'b1;
    logic        rw = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wrData = '0;
    logic [31:0] rdData;
    logic        rdy_;
    logic [7:0]  gpioIn = '0;
    logic [7:0]  GPIOOut;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    gpio_ctrl #(
        .OUT_CH    (8),
        .IN_CH     (8),
        .DATA_W    (32),
        .OUT_RESET (8'h00)
    ) dut (
        .clk     (clk),
        .reset_  (reset_),
        .cs_     (cs_),
        .as_     (as_),
        .rw      (rw),
        .addr    (addr),
        .wrData  (wrData),
        .rdData  (rdData),
        .rdy_    (rdy_),
        .gpioIn  (gpioIn),
        .GPIOOut (GPIOOut),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-level model: pins are seen by software two edges after sampling,
    // an edge is a pin that was low three edges ago and high two edges ago.
    logic [7:0]  m_out = '0, m_edge = '0, m_mask = '0;
    logic        m_irq = 1'b0, m_rdy = 1'b1;
    logic [31:0] m_rd = '0;
    logic [7:0]  pin_1 = '0, pin_2 = '0, pin_3 = '0;
    logic        t_acc;
    logic [7:0]  t_clr;
    logic [31:0] t_rd;

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_out = '0; m_edge = '0; m_mask = '0;
            m_irq = 1'b0; m_rdy = 1'b1; m_rd = '0;
            pin_1 = '0; pin_2 = '0; pin_3 = '0;
        end else begin
            t_acc = !cs_ && !as_;
            t_rd  = '0;
            if (t_acc && rw) begin
                case (addr)
                    2'd0: t_rd = {24'd0, pin_2};
                    2'd1: t_rd = {24'd0, m_out};
                    2'd2: t_rd = {24'd0, m_edge};
                    2'd3: t_rd = {24'd0, m_mask};
                endcase
            end
            t_clr = (t_acc && !rw && addr == 2'd2) ? wrData[7:0] : 8'h00;
            m_irq = (m_edge & m_mask) != 8'h00;
            m_edge = (m_edge & ~t_clr) | (pin_2 & ~pin_3);
            if (t_acc && !rw && addr == 2'd1) m_out = wrData[7:0];
            if (t_acc && !rw && addr == 2'd3) m_mask = wrData[7:0];
            m_rd  = t_rd;
            m_rdy = !t_acc;
            pin_3 = pin_2;
            pin_2 = pin_1;
            pin_1 = gpioIn;
        end
    end

    always @(negedge clk) begin
        chk("model_GPIOOut", {24'd0, GPIOOut}, {24'd0, m_out});
        chk("model_rdy_", {31'd0, rdy_}, {31'd0, m_rdy});
        chk("model_rdData", rdData, m_rd);
        chk("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end

    task automatic bus(input logic r, input logic [1:0] a, input logic [31:0] d);
        cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wrData = d;
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wrData = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus(1'b1, a, 32'd0);
        chk({name, "_rdy"}, {31'd0, rdy_}, 32'd0);
        chk(name, rdData, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_GPIOOut", {24'd0, GPIOOut}, 32'h00);
        chk("rst_rdy", {31'd0, rdy_}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_rdData", rdData, 32'd0);
        reset_ = 1'b1;
        rd_chk("mask_after_rst", 2'd3, 32'h0);

        bus(1'b0, 2'd1, 32'hFFFF_FFA5);
        chk("out_pins", {24'd0, GPIOOut}, 32'hA5);
        chk("out_wr_rdy", {31'd0, rdy_}, 32'd0);
        tick(1);
        chk("idle_rdy", {31'd0, rdy_}, 32'd1);
        rd_chk("out_rd", 2'd1, 32'h0000_00A5);

        gpioIn = 8'h08;
        rd_chk("in_lat0", 2'd0, 32'h0);
        rd_chk("in_lat1", 2'd0, 32'h0);
        rd_chk("in_lat2", 2'd0, 32'h08);
        rd_chk("edge_lat3", 2'd2, 32'h08);
        tick(3);
        chk("irq_unmasked", {31'd0, irq}, 32'd0);
        bus(1'b0, 2'd2, 32'h08);
        rd_chk("edge_cleared", 2'd2, 32'h0);
        gpioIn = 8'h00;
        tick(4);
        rd_chk("edge_fall", 2'd2, 32'h0);

        bus(1'b0, 2'd3, 32'hFFFF_FF08);
        rd_chk("mask_rd", 2'd3, 32'h08);
        gpioIn = 8'h08;
        tick(3);
        chk("irq_pre", {31'd0, irq}, 32'd0);
        rd_chk("edge_set", 2'd2, 32'h08);
        chk("irq_set", {31'd0, irq}, 32'd1);
        bus(1'b0, 2'd2, 32'h08);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        tick(1);
        chk("irq_drop", {31'd0, irq}, 32'd0);
        rd_chk("edge_w1c", 2'd2, 32'h0);

        gpioIn = 8'h00; tick(4);
        gpioIn = 8'h08; tick(4);
        chk("irq_again", {31'd0, irq}, 32'd1);
        gpioIn = 8'h00; tick(4);
        gpioIn = 8'h08; tick(2);
        bus(1'b0, 2'd2, 32'h08);
        chk("irq_collide", {31'd0, irq}, 32'd1);
        rd_chk("edge_collide", 2'd2, 32'h08);
        chk("irq_collide2", {31'd0, irq}, 32'd1);

        bus(1'b0, 2'd1, 32'h0000_003C);
        chk("b2b_rdy1", {31'd0, rdy_}, 32'd0);
        chk("b2b_pins", {24'd0, GPIOOut}, 32'h3C);
        rd_chk("b2b_out", 2'd1, 32'h3C);
        rd_chk("b2b_in", 2'd0, 32'h08);
        tick(1);
        chk("b2b_idle_rdy", {31'd0, rdy_}, 32'd1);
        chk("b2b_idle_rd", rdData, 32'd0);

        gpioIn = 8'h00; tick(4);
        rd_chk("pre_rst_mask", 2'd3, 32'h08);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 2'd1; wrData = 32'h77;
        #2;
        reset_ = 1'b0;
        #1;
        chk("arst_GPIOOut", {24'd0, GPIOOut}, 32'h00);
        chk("arst_rdy", {31'd0, rdy_}, 32'd1);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_rdData", rdData, 32'd0);
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wrData = '0;
        tick(1);
        reset_ = 1'b1;
        chk("post_rst_pins", {24'd0, GPIOOut}, 32'h00);
        rd_chk("post_rst_out", 2'd1, 32'h0);
        rd_chk("post_rst_mask", 2'd3, 32'h0);
        rd_chk("post_rst_edge", 2'd2, 32'h0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
